// File: rtl/channel_pkg.sv
// Shared types for the pole-residue channel model.
//   cfg_field_e  : which coefficient a config write targets
//   pole_coef_t  : one complex pole section (gain re/im, exponent re/im)
//   chan_state_e : commit FSM states
//   pole_stable  : |exp|^2 below a limit, used by the commit check
package channel_pkg;

  typedef enum logic [2:0] {
    FLD_GR = 3'd0,
    FLD_GI = 3'd1,
    FLD_ER = 3'd2,
    FLD_EI = 3'd3,
    FLD_DC = 3'd4
  } cfg_field_e;

  typedef struct {
    real gr;
    real gi;
    real er;
    real ei;
  } pole_coef_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } chan_state_e;

  // A section is accepted only while its pole magnitude squared stays below lim.
  function automatic logic pole_stable(input pole_coef_t c, input real lim);
    return (c.er * c.er + c.ei * c.ei) < lim;
  endfunction

endpackage

// File: rtl/pole_section.sv
// One first-order complex pole section.
//   ac[n+1] = exp * ac[n] + gain * x[n]   (complex exp, complex gain, real x)
// Ports:
//   clk, rst_n : sample clock, synchronous active-low reset
//   clr        : zero the state at this edge (commit with clear)
//   x          : channel input sample
//   coef       : active coefficients for this section
//   ac_r, ac_i : section state, real and imaginary parts
module pole_section
  import channel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  real        x,
  input  pole_coef_t coef,
  output real        ac_r,
  output real        ac_i
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      ac_r <= 0.0;
      ac_i <= 0.0;
    end else begin
      ac_r <= coef.er * ac_r - coef.ei * ac_i + coef.gr * x;
      ac_i <= coef.ei * ac_r + coef.er * ac_i + coef.gi * x;
    end
  end

endmodule

// File: rtl/channel_pr_model.sv
// Pole-residue channel model: y = dc*x + sum_k Re(ac_k), NPOLE complex sections.
// Coefficients are written into a shadow bank and copied to the active bank by a
// one-cycle, stability-checked commit.
// Ports:
//   clk, rst_n    : sample clock, synchronous active-low reset
//   x, y          : input sample, output sample (registered)
//   bypass        : y follows x; section states keep running
//   cfg_valid/ready, cfg_idx, cfg_field, cfg_data : shadow-bank write
//   cfg_commit, cfg_clr : request commit; cfg_clr zeroes section states with it
//   cfg_err       : sticky error (bad index or rejected commit)
//   y_settled     : SETTLE_CYC samples have elapsed since the last accepted commit
module channel_pr_model
  import channel_pkg::*;
#(
  parameter int  NPOLE      = 6,
  parameter int  SETTLE_CYC = 1024,
  parameter real STAB_MAX   = 1.0,
  localparam int IDX_W      = (NPOLE > 1) ? $clog2(NPOLE) : 1,
  localparam int CNT_W      = $clog2(SETTLE_CYC + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  real              x,
  input  logic             bypass,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  cfg_field_e       cfg_field,
  input  real              cfg_data,
  input  logic             cfg_commit,
  input  logic             cfg_clr,
  output logic             cfg_err,
  output real              y,
  output logic             y_settled
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYC);

  chan_state_e state_q, state_d, prev_q;

  pole_coef_t shadow [NPOLE];
  pole_coef_t active [NPOLE];
  real        shadow_dc, active_dc;
  real        ac_r   [NPOLE];
  real        pole_sum;

  logic             clr_q;
  logic [CNT_W-1:0] settle_cnt;
  logic             wr_acc, wr_bad, stable, commit_ok, pole_clr;

  // Writes are blocked only for the single COMMIT cycle.
  assign cfg_ready = (state_q != COMMIT);
  assign wr_acc    = cfg_valid && cfg_ready;
  assign wr_bad    = wr_acc && (cfg_field != FLD_DC) && (int'(cfg_idx) >= NPOLE);
  assign commit_ok = (state_q == COMMIT) && stable;
  assign pole_clr  = commit_ok && clr_q;
  assign y_settled = (settle_cnt == CNT_MAX);

  // Stability check looks at the shadow bank, which already contains any write
  // that arrived together with cfg_commit.
  always_comb begin
    stable = 1'b1;
    for (int k = 0; k < NPOLE; k++) begin
      if (!pole_stable(shadow[k], STAB_MAX)) stable = 1'b0;
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY, RUN: if (cfg_commit) state_d = COMMIT;
      COMMIT:     state_d = stable ? RUN : prev_q;
      default:    state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      prev_q  <= EMPTY;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Remember where to return on a rejected commit, and the clear request.
      if (state_q != COMMIT && cfg_commit) begin
        prev_q <= state_q;
        clr_q  <= cfg_clr;
      end
    end
  end

  // ---------------- coefficient banks ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NPOLE; k++) begin
        shadow[k].gr <= 0.0;
        shadow[k].gi <= 0.0;
        shadow[k].er <= 0.0;
        shadow[k].ei <= 0.0;
        active[k].gr <= 0.0;
        active[k].gi <= 0.0;
        active[k].er <= 0.0;
        active[k].ei <= 0.0;
      end
      shadow_dc <= 0.0;
      active_dc <= 0.0;
    end else begin
      if (wr_acc && !wr_bad) begin
        case (cfg_field)
          FLD_GR:  shadow[cfg_idx].gr <= cfg_data;
          FLD_GI:  shadow[cfg_idx].gi <= cfg_data;
          FLD_ER:  shadow[cfg_idx].er <= cfg_data;
          FLD_EI:  shadow[cfg_idx].ei <= cfg_data;
          FLD_DC:  shadow_dc          <= cfg_data;
          default: ;
        endcase
      end
      // Writes are not accepted in COMMIT, so the shadow is stable during the copy.
      if (commit_ok) begin
        for (int k = 0; k < NPOLE; k++) active[k] <= shadow[k];
        active_dc <= shadow_dc;
      end
    end
  end

  // ---------------- error flag and settle counter ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err    <= 1'b0;
      settle_cnt <= '0;
    end else begin
      if (wr_bad || (state_q == COMMIT && !stable)) cfg_err <= 1'b1;
      if (commit_ok)
        settle_cnt <= '0;
      else if (state_q == RUN && settle_cnt != CNT_MAX)
        settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // ---------------- pole sections ----------------
  for (genvar k = 0; k < NPOLE; k++) begin : g_pole
    pole_section u_pole (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (pole_clr),
      .x    (x),
      .coef (active[k]),
      .ac_r (ac_r[k]),
      .ac_i ()
    );
  end

  // ---------------- output ----------------
  // Uses the pre-edge section states, so a pole contributes one sample after dc.
  always_comb begin
    pole_sum = 0.0;
    for (int k = 0; k < NPOLE; k++) pole_sum = pole_sum + ac_r[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) y <= 0.0;
    else        y <= bypass ? x : (active_dc * x + pole_sum);
  end

endmodule

// File: tb/tb_channel_pr_model.sv
module tb_channel_pr_model;
  import channel_pkg::*;

  localparam int NP = 3;
  localparam int SC = 8;

  logic       clk, rst_n;
  real        x;
  logic       bypass, cfg_valid, cfg_ready;
  logic [1:0] cfg_idx;
  cfg_field_e cfg_field;
  real        cfg_data;
  logic       cfg_commit, cfg_clr, cfg_err;
  real        y;
  logic       y_settled;

  int errors = 0;
  int checks = 0;

  channel_pr_model #(.NPOLE(NP), .SETTLE_CYC(SC), .STAB_MAX(1.0)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .bypass(bypass),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_clr(cfg_clr), .cfg_err(cfg_err), .y(y), .y_settled(y_settled)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (behavioural) ----------------
  typedef struct {
    real  y;
    logic settled;
    logic err;
    logic ready;
  } exp_t;
  exp_t sbq[$];

  real sgr[NP], sgi[NP], ser[NP], sei[NP], sdc;   // shadow bank
  real agr[NP], agi[NP], aer[NP], aei[NP], adc;   // active bank
  real ar[NP], ai[NP];                             // section states
  bit  m_run, m_pend, m_clrp, m_err;
  int  m_cnt;

  task automatic model_edge();
    real  ny, nr[NP], ni[NP], s;
    bit   ok;
    int   idx;
    exp_t e;
    if (!rst_n) begin
      for (int k = 0; k < NP; k++) begin
        sgr[k] = 0.0; sgi[k] = 0.0; ser[k] = 0.0; sei[k] = 0.0;
        agr[k] = 0.0; agi[k] = 0.0; aer[k] = 0.0; aei[k] = 0.0;
        ar[k] = 0.0; ai[k] = 0.0;
      end
      sdc = 0.0; adc = 0.0;
      m_run = 0; m_pend = 0; m_clrp = 0; m_err = 0; m_cnt = 0;
      ny = 0.0;
    end else begin
      s = 0.0;
      for (int k = 0; k < NP; k++) s = s + ar[k];
      ny = bypass ? x : adc * x + s;
      for (int k = 0; k < NP; k++) begin
        nr[k] = aer[k] * ar[k] - aei[k] * ai[k] + agr[k] * x;
        ni[k] = aei[k] * ar[k] + aer[k] * ai[k] + agi[k] * x;
      end
      if (m_run && !m_pend && m_cnt < SC) m_cnt++;
      if (!m_pend && cfg_valid) begin
        idx = int'(cfg_idx);
        if (cfg_field != FLD_DC && idx >= NP) m_err = 1;
        else begin
          case (cfg_field)
            FLD_GR: sgr[idx] = cfg_data;
            FLD_GI: sgi[idx] = cfg_data;
            FLD_ER: ser[idx] = cfg_data;
            FLD_EI: sei[idx] = cfg_data;
            default: sdc = cfg_data;
          endcase
        end
      end
      if (m_pend) begin
        ok = 1;
        for (int k = 0; k < NP; k++)
          if (ser[k] * ser[k] + sei[k] * sei[k] >= 1.0) ok = 0;
        if (ok) begin
          for (int k = 0; k < NP; k++) begin
            agr[k] = sgr[k]; agi[k] = sgi[k]; aer[k] = ser[k]; aei[k] = sei[k];
            if (m_clrp) begin nr[k] = 0.0; ni[k] = 0.0; end
          end
          adc = sdc; m_cnt = 0; m_run = 1;
        end else m_err = 1;
        m_pend = 0;
      end else if (cfg_commit) begin
        m_pend = 1; m_clrp = cfg_clr;
      end
      for (int k = 0; k < NP; k++) begin ar[k] = nr[k]; ai[k] = ni[k]; end
    end
    e.y = ny; e.settled = (m_cnt == SC); e.err = m_err; e.ready = !m_pend;
    sbq.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    real  tol;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        tol = 1e-9 * (1.0 + (e.y < 0.0 ? -e.y : e.y));
        checks++;
        if (y - e.y > tol || e.y - y > tol) begin
          errors++; $display("FAIL sb_y: got %g want %g at %0t", y, e.y, $time);
        end
        checks++;
        if (y_settled !== e.settled) begin
          errors++; $display("FAIL sb_settled: got %b want %b at %0t", y_settled, e.settled, $time);
        end
        checks++;
        if (cfg_err !== e.err) begin
          errors++; $display("FAIL sb_err: got %b want %b at %0t", cfg_err, e.err, $time);
        end
        checks++;
        if (cfg_ready !== e.ready) begin
          errors++; $display("FAIL sb_ready: got %b want %b at %0t", cfg_ready, e.ready, $time);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic chk_real(input string nm, input real act, input real expv, input real tol);
    checks++;
    if (act - expv > tol || expv - act > tol) begin
      errors++; $display("FAIL %s: got %g want %g", nm, act, expv);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++; $display("FAIL %s: got %b want %b", nm, act, expv);
    end
  endtask

  task automatic wr(input cfg_field_e f, input int idx, input real d);
    cfg_valid = 1'b1; cfg_field = f; cfg_idx = 2'(idx); cfg_data = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic commit(input logic clr);
    cfg_commit = 1'b1; cfg_clr = clr;
    step();
    cfg_commit = 1'b0; cfg_clr = 1'b0;
    chk_bit("commit_ready_low", cfg_ready, 1'b0);
    step();
  endtask

  function automatic real rnd(input real span);
    return span * (real'(int'($urandom_range(0, 2000)) - 1000) / 1000.0);
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n = 1'b0; x = 0.0; bypass = 1'b0; cfg_valid = 1'b0; cfg_idx = '0;
    cfg_field = FLD_GR; cfg_data = 0.0; cfg_commit = 1'b0; cfg_clr = 1'b0;
    step(); step();
    chk_bit("reset_ready", cfg_ready, 1'b1);
    chk_bit("reset_err", cfg_err, 1'b0);
    chk_real("reset_y", y, 0.0, 0.0);
    rst_n = 1'b1;
    step();

    // T1 impulse through one real pole, then settle timing
    wr(FLD_GR, 0, 1.0);
    wr(FLD_ER, 0, 0.5);
    commit(1'b1);
    x = 1.0; step(); chk_real("t1_y0", y, 0.0, 0.0);
    x = 0.0; step(); chk_real("t1_y1", y, 1.0, 0.0);
    step();          chk_real("t1_y2", y, 0.5, 0.0);
    step();          chk_real("t1_y3", y, 0.25, 0.0);
    repeat (3) step();
    chk_bit("t6_settle_7", y_settled, 1'b0);
    step();
    chk_bit("t6_settle_8", y_settled, 1'b1);

    // T2 DC gain
    wr(FLD_GR, 0, 0.5);
    wr(FLD_DC, 0, 0.25);
    commit(1'b1);
    x = 1.0;
    repeat (60) step();
    chk_real("t2_dc_gain", y, 1.25, 1e-9);

    // T3 unstable commit is rejected, output keeps running on the old bank
    wr(FLD_ER, 0, 1.0);
    commit(1'b0);
    chk_bit("t3_err", cfg_err, 1'b1);
    step();
    chk_real("t3_y_cont", y, 1.25, 1e-9);
    wr(FLD_ER, 0, 0.5);

    // T5 reset mid-run
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk_real("t5_y", y, 0.0, 0.0);
    chk_bit("t5_settled", y_settled, 1'b0);
    chk_bit("t5_err", cfg_err, 1'b0);
    repeat (5) step();
    chk_real("t5_empty_y", y, 0.0, 0.0);

    // T4 bad index, then write in the same cycle as commit
    wr(FLD_GR, NP, 2.0);
    chk_bit("t4_bad_idx_err", cfg_err, 1'b1);
    wr(FLD_GR, 0, 1.0);
    wr(FLD_ER, 0, 0.5);
    cfg_valid = 1'b1; cfg_field = FLD_DC; cfg_idx = '0; cfg_data = 0.5;
    cfg_commit = 1'b1; cfg_clr = 1'b1;
    step();
    cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_clr = 1'b0;
    step();
    step(); chk_real("t4_wc_dc", y, 0.5, 0.0);
    step(); chk_real("t4_wc_pole", y, 1.5, 0.0);

    // T6 bypass tracks x one sample later
    bypass = 1'b1;
    for (int i = 0; i < 10; i++) begin
      x = rnd(2.0);
      step();
      chk_real("t6_bypass", y, x, 0.0);
    end
    bypass = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      rst_n      = ($urandom_range(0, 149) != 0);
      bypass     = ($urandom_range(0, 7) == 0);
      x          = rnd(1.0);
      cfg_valid  = ($urandom_range(0, 2) == 0);
      cfg_idx    = 2'($urandom_range(0, 3));
      cfg_field  = cfg_field_e'($urandom_range(0, 4));
      cfg_data   = ($urandom_range(0, 1) == 0) ? rnd(1.05) : rnd(1.0);
      cfg_commit = ($urandom_range(0, 9) == 0);
      cfg_clr    = 1'($urandom_range(0, 1));
      step();
    end
    rst_n = 1'b1; cfg_valid = 1'b0; cfg_commit = 1'b0;

    @(negedge clk); #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d left want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
